branch_pc_sequencer: RTL and testbench

Owns the architectural program counter and consumes the decoded branch controls (`branch_op`, `branch_base_src`, `branch_offset_src`) for each instruction. It resolves taken/not-taken from the ALU zero flag and computes the target. It then drives the next fetch address with a valid/ready handshake toward the fetch/execute path. It sits between the instruction branch-select decoder and instruction fetch, and inserts a one-cycle flush bubble on every redirect.

---
 rtl/branch_pkg.sv | 36 +++
 rtl/branch_imm_extract.sv | 30 +++
 rtl/branch_pc_sequencer.sv | 167 ++++++++++++++++
 tb/tb_branch_pc_sequencer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : branch_pkg
// Purpose  : Shared branch-control encodings and sequencer state type, used by
//            the branch-select decoder and the PC sequencer.
// Contents : BRANCH_* (2-bit branch condition codes)
//            ALU_SRC_* (3-bit base/offset source selects)
//            state_t (sequencer FSM states)
// Revision : 1.0  initial release
// ============================================================================
package branch_pkg;

  // Branch condition codes
  localparam logic [1:0] BRANCH_NEVER   = 2'b00;
  localparam logic [1:0] BRANCH_NONZERO = 2'b01;
  localparam logic [1:0] BRANCH_ZERO    = 2'b10;
  localparam logic [1:0] BRANCH_ALWAYS  = 2'b11;

  // Base / offset source selects (shared code space)
  localparam logic [2:0] ALU_SRC_ZERO   = 3'b000;
  localparam logic [2:0] ALU_SRC_FOUR   = 3'b001;
  localparam logic [2:0] ALU_SRC_PC     = 3'b010;
  localparam logic [2:0] ALU_SRC_REG    = 3'b011;
  localparam logic [2:0] ALU_SRC_IMM12  = 3'b100;
  localparam logic [2:0] ALU_SRC_JUMP   = 3'b110;
  localparam logic [2:0] ALU_SRC_BRANCH = 3'b111;

  typedef enum logic [1:0] {
    RESET = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    HALT  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/branch_imm_extract.sv
`default_nettype none
// ============================================================================
// Module   : branch_imm_extract
// Purpose  : Pure combinational extraction of the I/B/J immediates from an
//            RV32-style instruction word, each sign-extended to 32 bits.
// Ports    : instr      in  32  instruction word
//            imm12      out 32  I-type immediate
//            imm_branch out 32  B-type immediate (bit 0 always 0)
//            imm_jump   out 32  J-type immediate (bit 0 always 0)
// Revision : 1.0  initial release
// ============================================================================
module branch_imm_extract (
  input  logic [31:0] instr,
  output logic [31:0] imm12,
  output logic [31:0] imm_branch,
  output logic [31:0] imm_jump
);

  // Opcode bits carry no immediate information.
  logic w_unused_opcode;
  assign w_unused_opcode = ^instr[6:0];

  assign imm12      = {{20{instr[31]}}, instr[31:20]};
  assign imm_branch = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                       instr[11:8], 1'b0};
  assign imm_jump   = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                       instr[30:21], 1'b0};

endmodule
`default_nettype wire

// File: rtl/branch_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : branch_pc_sequencer
// Purpose  : Owns the program counter. Resolves taken/not-taken for each
//            accepted instruction, computes the branch target, inserts a
//            one-cycle flush bubble on every redirect and halts with a
//            sticky trap on a misaligned taken target.
// Ports    : clk, rst_n (async active-low)
//            instr, instr_valid, instr_ready, stall
//            branch_op, branch_base_src, branch_offset_src, rs1_value, alu_zero
//            pc, pc_valid, redirect, flush, trap, trap_pc
// Revision : 1.0  initial release
// ============================================================================
module branch_pc_sequencer
  import branch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic        stall,
  input  logic [1:0]  branch_op,
  input  logic [2:0]  branch_base_src,
  input  logic [2:0]  branch_offset_src,
  input  logic [31:0] rs1_value,
  input  logic        alu_zero,
  output logic [31:0] pc,
  output logic        pc_valid,
  output logic        redirect,
  output logic        flush,
  output logic        trap,
  output logic [31:0] trap_pc
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic        r_flush;
  logic        r_redirect;
  logic        r_trap;
  logic [31:0] r_trap_pc;
  logic        w_trap_set;

  logic [31:0] w_imm12;
  logic [31:0] w_imm_branch;
  logic [31:0] w_imm_jump;
  logic        w_accept;
  logic        w_taken;
  logic [31:0] w_base;
  logic [31:0] w_offset;
  logic [31:0] w_sum;
  logic [31:0] w_target;
  logic [31:0] w_pc_plus4;
  logic        w_misaligned;

  branch_imm_extract u_imm (
    .instr      (instr),
    .imm12      (w_imm12),
    .imm_branch (w_imm_branch),
    .imm_jump   (w_imm_jump)
  );

  assign instr_ready = (r_state == RUN) & ~stall;
  assign w_accept    = instr_valid & instr_ready;

  // Unknown condition codes fall to the default arm and resolve not-taken.
  always_comb begin
    w_taken = 1'b0;
    case (branch_op)
      BRANCH_NEVER:   w_taken = 1'b0;
      BRANCH_NONZERO: w_taken = ~alu_zero;
      BRANCH_ZERO:    w_taken = alu_zero;
      BRANCH_ALWAYS:  w_taken = 1'b1;
      default:        w_taken = 1'b0;
    endcase
  end

  always_comb begin
    w_base = 32'd0;
    case (branch_base_src)
      ALU_SRC_ZERO: w_base = 32'd0;
      ALU_SRC_FOUR: w_base = 32'd4;
      ALU_SRC_PC:   w_base = r_pc;
      ALU_SRC_REG:  w_base = rs1_value;
      default:      w_base = 32'd0;
    endcase
  end

  always_comb begin
    w_offset = 32'd0;
    case (branch_offset_src)
      ALU_SRC_ZERO:   w_offset = 32'd0;
      ALU_SRC_FOUR:   w_offset = 32'd4;
      ALU_SRC_IMM12:  w_offset = w_imm12;
      ALU_SRC_JUMP:   w_offset = w_imm_jump;
      ALU_SRC_BRANCH: w_offset = w_imm_branch;
      default:        w_offset = 32'd0;
    endcase
  end

  // Register-relative jumps clear bit 0 of the sum (JALR semantics).
  assign w_sum        = w_base + w_offset;
  assign w_target     = {w_sum[31:1],
                         w_sum[0] & (branch_base_src != ALU_SRC_REG)};
  assign w_pc_plus4   = r_pc + 32'd4;
  assign w_misaligned = (w_target[1:0] != 2'b00);

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_trap_set  = 1'b0;
    case (r_state)
      RESET: w_state_nxt = RUN;
      RUN: begin
        if (w_accept) begin
          if (!w_taken) begin
            w_pc_nxt = w_pc_plus4;
          end else if (w_misaligned) begin
            w_trap_set  = 1'b1;
            w_state_nxt = HALT;
          end else begin
            w_pc_nxt    = w_target;
            w_state_nxt = FLUSH;
          end
        end
      end
      FLUSH:   w_state_nxt = RUN;
      HALT:    w_state_nxt = HALT;
      default: w_state_nxt = RESET;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= RESET;
      r_pc       <= RESET_PC;
      r_flush    <= 1'b0;
      r_redirect <= 1'b0;
      r_trap     <= 1'b0;
      r_trap_pc  <= 32'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      // Flush/redirect are registered copies of "entering FLUSH", so they are
      // high for exactly the one FLUSH cycle.
      r_flush    <= (w_state_nxt == FLUSH);
      r_redirect <= (w_state_nxt == FLUSH);
      if (w_trap_set) begin
        r_trap    <= 1'b1;
        r_trap_pc <= r_pc;
      end
    end
  end

  assign pc       = r_pc;
  assign pc_valid = (r_state == RUN) | (r_state == FLUSH);
  assign redirect = r_redirect;
  assign flush    = r_flush;
  assign trap     = r_trap;
  assign trap_pc  = r_trap_pc;

endmodule
`default_nettype wire

// File: tb/tb_branch_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_pc_sequencer
// Purpose  : Self-checking bench for branch_pc_sequencer: a table of directed
//            single-instruction vectors plus hand-written stall, reset-in-
//            flush and misaligned-trap sequences.
// Revision : 1.0  initial release
// ============================================================================
module tb_branch_pc_sequencer;
  import branch_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        stall;
  logic [1:0]  branch_op;
  logic [2:0]  branch_base_src;
  logic [2:0]  branch_offset_src;
  logic [31:0] rs1_value;
  logic        alu_zero;
  logic [31:0] pc;
  logic        pc_valid;
  logic        redirect;
  logic        flush;
  logic        trap;
  logic [31:0] trap_pc;

  int n_checks = 0;
  int n_errors = 0;

  branch_pc_sequencer #(.RESET_PC(32'h100)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .instr             (instr),
    .instr_valid       (instr_valid),
    .instr_ready       (instr_ready),
    .stall             (stall),
    .branch_op         (branch_op),
    .branch_base_src   (branch_base_src),
    .branch_offset_src (branch_offset_src),
    .rs1_value         (rs1_value),
    .alu_zero          (alu_zero),
    .pc                (pc),
    .pc_valid          (pc_valid),
    .redirect          (redirect),
    .flush             (flush),
    .trap              (trap),
    .trap_pc           (trap_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [1:0]  op;
    logic [2:0]  base;
    logic [2:0]  offs;
    logic [31:0] rs1;
    logic        zero;
    logic [31:0] exp_pc;
    logic        exp_taken;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    instr             = v.instr;
    branch_op         = v.op;
    branch_base_src   = v.base;
    branch_offset_src = v.offs;
    rs1_value         = v.rs1;
    alu_zero          = v.zero;
  endtask

  // Called at posedge+1 in RUN; returns at posedge+1 with the sequencer back
  // in RUN.
  task automatic apply(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    drive(v);
    instr_valid = 1'b1;
    #1;
    check({tag, " ready"}, {31'd0, instr_ready}, 32'd1);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    check({tag, " pc"}, pc, v.exp_pc);
    check({tag, " pc_valid"}, {31'd0, pc_valid}, 32'd1);
    check({tag, " flush"}, {31'd0, flush}, {31'd0, v.exp_taken});
    check({tag, " redirect"}, {31'd0, redirect}, {31'd0, v.exp_taken});
    if (v.exp_taken) begin
      check({tag, " ready_in_flush"}, {31'd0, instr_ready}, 32'd0);
      @(posedge clk); #1;
      check({tag, " flush_drop"}, {31'd0, flush}, 32'd0);
      check({tag, " pc_after_flush"}, pc, v.exp_pc);
    end
  endtask

  vec_t vecs[16];
  vec_t v;

  initial begin
    // Not-taken x3 from 0x100, then redirects and corner targets.
    vecs[0]  = '{32'h0,        BRANCH_NEVER,   ALU_SRC_PC,   ALU_SRC_BRANCH, 32'h0,    1'b0, 32'h104,      1'b0};
    vecs[1]  = '{32'h0,        BRANCH_NEVER,   ALU_SRC_PC,   ALU_SRC_BRANCH, 32'h0,    1'b0, 32'h108,      1'b0};
    vecs[2]  = '{32'h0,        BRANCH_NEVER,   ALU_SRC_PC,   ALU_SRC_BRANCH, 32'h0,    1'b0, 32'h10C,      1'b0};
    vecs[3]  = '{32'h20000000, BRANCH_ALWAYS,  ALU_SRC_ZERO, ALU_SRC_IMM12,  32'h0,    1'b0, 32'h200,      1'b1};
    vecs[4]  = '{32'h00000863, BRANCH_ZERO,    ALU_SRC_PC,   ALU_SRC_BRANCH, 32'h0,    1'b1, 32'h210,      1'b1};
    vecs[5]  = '{32'h20000000, BRANCH_ALWAYS,  ALU_SRC_ZERO, ALU_SRC_IMM12,  32'h0,    1'b0, 32'h200,      1'b1};
    vecs[6]  = '{32'h00000863, BRANCH_ZERO,    ALU_SRC_PC,   ALU_SRC_BRANCH, 32'h0,    1'b0, 32'h204,      1'b0};
    vecs[7]  = '{32'h00000863, BRANCH_NONZERO, ALU_SRC_PC,   ALU_SRC_BRANCH, 32'h0,    1'b0, 32'h214,      1'b1};
    vecs[8]  = '{32'h00400067, BRANCH_ALWAYS,  ALU_SRC_REG,  ALU_SRC_IMM12,  32'h1001, 1'b0, 32'h1004,     1'b1};
    vecs[9]  = '{32'h0,        BRANCH_ALWAYS,  ALU_SRC_FOUR, ALU_SRC_FOUR,   32'h0,    1'b0, 32'h8,        1'b1};
    vecs[10] = '{32'h0,        BRANCH_ALWAYS,  ALU_SRC_ZERO, ALU_SRC_ZERO,   32'h0,    1'b0, 32'h0,        1'b1};
    vecs[11] = '{32'hFF9FF06F, BRANCH_ALWAYS,  ALU_SRC_PC,   ALU_SRC_JUMP,   32'h0,    1'b0, 32'hFFFFFFF8, 1'b1};
    vecs[12] = '{32'h0,        BRANCH_NONZERO, ALU_SRC_PC,   ALU_SRC_BRANCH, 32'h0,    1'b1, 32'hFFFFFFFC, 1'b0};
    vecs[13] = '{32'h0,        BRANCH_NEVER,   ALU_SRC_PC,   ALU_SRC_BRANCH, 32'h0,    1'b0, 32'h0,        1'b0};
    vecs[14] = '{32'h0,        BRANCH_ALWAYS,  ALU_SRC_FOUR, 3'b101,         32'h0,    1'b0, 32'h4,        1'b1};
    vecs[15] = '{32'h00000863, BRANCH_ZERO,    ALU_SRC_PC,   ALU_SRC_BRANCH, 32'h0,    1'b0, 32'h8,        1'b0};

    rst_n = 1'b0;
    instr_valid = 1'b0;
    stall = 1'b0;
    instr = 32'h0;
    branch_op = 2'b00;
    branch_base_src = 3'b000;
    branch_offset_src = 3'b000;
    rs1_value = 32'h0;
    alu_zero = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst pc", pc, 32'h100);
    check("rst pc_valid", {31'd0, pc_valid}, 32'd0);
    check("rst ready", {31'd0, instr_ready}, 32'd0);
    check("rst redirect", {31'd0, redirect}, 32'd0);
    check("rst flush", {31'd0, flush}, 32'd0);
    check("rst trap", {31'd0, trap}, 32'd0);
    check("rst trap_pc", trap_pc, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("run pc", pc, 32'h100);
    check("run pc_valid", {31'd0, pc_valid}, 32'd1);

    for (int i = 0; i < 16; i++) apply(vecs[i], i);

    // Stall holds PC for three cycles, then a taken branch redirects and
    // reset lands in the middle of the FLUSH cycle.
    v = '{32'h20000000, BRANCH_ALWAYS, ALU_SRC_ZERO, ALU_SRC_IMM12, 32'h0, 1'b0, 32'h200, 1'b1};
    drive(v);
    instr_valid = 1'b1;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall ready", {31'd0, instr_ready}, 32'd0);
      @(posedge clk); #1;
      check("stall pc", pc, 32'h8);
      check("stall flush", {31'd0, flush}, 32'd0);
    end
    stall = 1'b0;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    check("unstall pc", pc, 32'h200);
    check("unstall flush", {31'd0, flush}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midflush rst pc", pc, 32'h100);
    check("midflush rst flush", {31'd0, flush}, 32'd0);
    check("midflush rst redirect", {31'd0, redirect}, 32'd0);
    check("midflush rst pc_valid", {31'd0, pc_valid}, 32'd0);
    check("midflush rst ready", {31'd0, instr_ready}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rerun pc", pc, 32'h100);
    check("rerun pc_valid", {31'd0, pc_valid}, 32'd1);

    // Misaligned taken target traps and halts.
    v = '{32'h30000000, BRANCH_ALWAYS, ALU_SRC_ZERO, ALU_SRC_IMM12, 32'h0, 1'b0, 32'h300, 1'b1};
    apply(v, 100);
    v = '{32'h00000100, BRANCH_ALWAYS, ALU_SRC_PC, ALU_SRC_BRANCH, 32'h0, 1'b0, 32'h0, 1'b0};
    drive(v);
    instr_valid = 1'b1;
    @(posedge clk); #1;
    check("trap", {31'd0, trap}, 32'd1);
    check("trap_pc", trap_pc, 32'h300);
    check("halt pc", pc, 32'h300);
    check("halt pc_valid", {31'd0, pc_valid}, 32'd0);
    check("halt ready", {31'd0, instr_ready}, 32'd0);
    check("halt flush", {31'd0, flush}, 32'd0);
    branch_op = BRANCH_NEVER;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("halt hold pc", pc, 32'h300);
      check("halt hold trap", {31'd0, trap}, 32'd1);
    end
    instr_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("halt rst trap", {31'd0, trap}, 32'd0);
    check("halt rst trap_pc", trap_pc, 32'h0);
    check("halt rst pc", pc, 32'h100);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post halt pc_valid", {31'd0, pc_valid}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
